// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//
// Pipeline hazard controller for the RV32IM core. A shadow EX/MEM/WB pipeline
// keeps the destination registers of in-flight instructions. From it the unit
// drives the one-hot EX operand selects and raises a stall for load-use hazards
// and for multi-cycle MUL/DIV execution.
//
// Optional feature macro: HAZARD_MULDIV_EN
//   defined   - a 4-bit busy counter freezes a MUL/DIV in EX for MULDIV_CYCLES
//   undefined - ID_IS_MULDIV is ignored; MUL/DIV ops behave as single-cycle ALU ops
//
// Ports
//   CLK          in   rising-edge clock
//   RESET        in   synchronous, active-high reset
//   ID_VALID     in   instruction present in ID
//   ID_RS1/2     in   ID source registers
//   ID_RD        in   ID destination register
//   ID_REG_WRITE in   ID instruction writes ID_RD
//   ID_IS_LOAD   in   ID instruction is a load
//   ID_IS_MULDIV in   ID instruction is an M-extension op
//   SEL1/SEL2    out  one-hot operand select: 001 regfile, 010 EX/MEM, 100 MEM/WB
//   STALL        out  hold PC and IF/ID this cycle
//   EX_BUBBLE    out  EX slot holds no valid instruction

module hazard_forward_unit #(
   parameter int unsigned MULDIV_CYCLES = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ID_VALID,
   input  logic [4:0] ID_RS1,
   input  logic [4:0] ID_RS2,
   input  logic [4:0] ID_RD,
   input  logic       ID_REG_WRITE,
   input  logic       ID_IS_LOAD,
   input  logic       ID_IS_MULDIV,
   output logic [2:0] SEL1,
   output logic [2:0] SEL2,
   output logic       STALL,
   output logic       EX_BUBBLE
);

   localparam logic [2:0] SelRf  = 3'b001;
   localparam logic [2:0] SelMem = 3'b010;
   localparam logic [2:0] SelWb  = 3'b100;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_write;
      logic       is_load;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       is_muldiv;
   } ex_slot_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_write;
      logic       is_load;
   } slot_t;

   ex_slot_t ex_q, ex_d;
   slot_t    mem_q, mem_d;
   slot_t    wb_q, wb_d;

   logic ex_eff, mem_eff, wb_eff;
   logic load_use;
   logic busy;

   assign ex_eff  = ex_q.valid  && ex_q.reg_write  && (ex_q.rd  != 5'd0);
   assign mem_eff = mem_q.valid && mem_q.reg_write && (mem_q.rd != 5'd0);
   assign wb_eff  = wb_q.valid  && wb_q.reg_write  && (wb_q.rd  != 5'd0);

`ifdef HAZARD_MULDIV_EN
   localparam logic [3:0] MulLoad = 4'(MULDIV_CYCLES - 1);

   logic [3:0] cnt_q, cnt_d;

   assign busy = (cnt_q != 4'd0);

   logic unused_bits;
   assign unused_bits = ^{ex_q.is_muldiv, mem_q.is_load, wb_q.is_load};
`else
   assign busy = 1'b0;

   logic unused_bits;
   assign unused_bits = ^{ex_q.is_muldiv, mem_q.is_load, wb_q.is_load, 32'(MULDIV_CYCLES)};
`endif

   // Both sources are compared regardless of format; a false stall only costs a cycle.
   assign load_use = ID_VALID && ex_eff && ex_q.is_load &&
                     ((ID_RS1 == ex_q.rd) || (ID_RS2 == ex_q.rd));

   assign STALL     = busy || load_use;
   assign EX_BUBBLE = !ex_q.valid;

   // Selects depend on slot registers only; MEM wins over WB as the younger result.
   always_comb begin
      SEL1 = SelRf;
      SEL2 = SelRf;
      if (ex_q.valid) begin
         if (mem_eff && (mem_q.rd == ex_q.rs1)) begin
            SEL1 = SelMem;
         end else if (wb_eff && (wb_q.rd == ex_q.rs1)) begin
            SEL1 = SelWb;
         end
         if (mem_eff && (mem_q.rd == ex_q.rs2)) begin
            SEL2 = SelMem;
         end else if (wb_eff && (wb_q.rd == ex_q.rs2)) begin
            SEL2 = SelWb;
         end
      end
   end

   always_comb begin
      ex_d  = ex_q;
      mem_d = '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write,
                is_load: ex_q.is_load};
      wb_d  = mem_q;
`ifdef HAZARD_MULDIV_EN
      cnt_d = cnt_q;
`endif
      if (busy) begin
         // MUL/DIV frozen in EX; bubbles drain towards WB behind it.
         ex_d  = ex_q;
         mem_d = '0;
`ifdef HAZARD_MULDIV_EN
         cnt_d = cnt_q - 4'd1;
`endif
      end else if (load_use) begin
         // The load moves on to MEM; its consumer later picks it up from MEM/WB.
         ex_d = '0;
      end else begin
         ex_d = '0;
         if (ID_VALID) begin
            ex_d = '{valid: 1'b1, rd: ID_RD, reg_write: ID_REG_WRITE, is_load: ID_IS_LOAD,
                     rs1: ID_RS1, rs2: ID_RS2, is_muldiv: ID_IS_MULDIV};
         end
`ifdef HAZARD_MULDIV_EN
         cnt_d = (ID_VALID && ID_IS_MULDIV) ? MulLoad : 4'd0;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
`ifdef HAZARD_MULDIV_EN
         cnt_q <= 4'd0;
`endif
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
`ifdef HAZARD_MULDIV_EN
         cnt_q <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Testbench for hazard_forward_unit. Each driven cycle pushes the outputs
// expected for that cycle; a monitor pops and compares them at the falling edge.

module tb_hazard_forward_unit;

   logic       CLK;
   logic       RESET;
   logic       ID_VALID;
   logic [4:0] ID_RS1;
   logic [4:0] ID_RS2;
   logic [4:0] ID_RD;
   logic       ID_REG_WRITE;
   logic       ID_IS_LOAD;
   logic       ID_IS_MULDIV;
   logic [2:0] SEL1;
   logic [2:0] SEL2;
   logic       STALL;
   logic       EX_BUBBLE;

   hazard_forward_unit #(
      .MULDIV_CYCLES(4)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .ID_VALID    (ID_VALID),
      .ID_RS1      (ID_RS1),
      .ID_RS2      (ID_RS2),
      .ID_RD       (ID_RD),
      .ID_REG_WRITE(ID_REG_WRITE),
      .ID_IS_LOAD  (ID_IS_LOAD),
      .ID_IS_MULDIV(ID_IS_MULDIV),
      .SEL1        (SEL1),
      .SEL2        (SEL2),
      .STALL       (STALL),
      .EX_BUBBLE   (EX_BUBBLE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      string      tag;
      logic [2:0] s1;
      logic [2:0] s2;
      logic       st;
      logic       bub;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         check({mon_e.tag, ".sel1"},  {5'd0, SEL1},      {5'd0, mon_e.s1});
         check({mon_e.tag, ".sel2"},  {5'd0, SEL2},      {5'd0, mon_e.s2});
         check({mon_e.tag, ".stall"}, {7'd0, STALL},     {7'd0, mon_e.st});
         check({mon_e.tag, ".bub"},   {7'd0, EX_BUBBLE}, {7'd0, mon_e.bub});
      end
   end

   // Drive one cycle of ID inputs and queue the outputs expected in that cycle.
   task automatic cyc(input string tag, input logic rst, input logic v,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic rw, input logic ld, input logic md,
                      input logic [2:0] e1, input logic [2:0] e2,
                      input logic est, input logic ebub);
      exp_t e;
      RESET        = rst;
      ID_VALID     = v;
      ID_RS1       = rs1;
      ID_RS2       = rs2;
      ID_RD        = rd;
      ID_REG_WRITE = rw;
      ID_IS_LOAD   = ld;
      ID_IS_MULDIV = md;
      e.tag = tag;
      e.s1  = e1;
      e.s2  = e2;
      e.st  = est;
      e.bub = ebub;
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic alu(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [2:0] e1, input logic [2:0] e2,
                      input logic est, input logic ebub);
      cyc(tag, 1'b0, 1'b1, rs1, rs2, rd, 1'b1, 1'b0, 1'b0, e1, e2, est, ebub);
   endtask

   task automatic nop(input string tag, input logic [2:0] e1, input logic [2:0] e2,
                      input logic est, input logic ebub);
      cyc(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, e1, e2, est, ebub);
   endtask

   localparam logic [2:0] R = 3'b001;
   localparam logic [2:0] M = 3'b010;
   localparam logic [2:0] W = 3'b100;

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      RESET = 1'b1;
      ID_VALID = 1'b0;
      ID_RS1 = '0;
      ID_RS2 = '0;
      ID_RD = '0;
      ID_REG_WRITE = 1'b0;
      ID_IS_LOAD = 1'b0;
      ID_IS_MULDIV = 1'b0;
      @(posedge CLK);
      #1;

      // Reset held with random ID traffic, then one cycle after release.
      for (int i = 0; i < 2; i++) begin
         r = $urandom;
         cyc("rst", 1'b1, r[0], r[5:1], r[10:6], r[15:11], r[16], r[17], r[18], R, R, 1'b0, 1'b1);
      end
      nop("post_rst", R, R, 1'b0, 1'b1);

      // EX/MEM forwarding, then the same with rd = x0.
      alu("c1", 5'd1, 5'd2, 5'd5, R, R, 1'b0, 1'b1);
      alu("c2", 5'd5, 5'd7, 5'd6, R, R, 1'b0, 1'b0);
      nop("c3_exmem", M, R, 1'b0, 1'b0);
      nop("c4", R, R, 1'b0, 1'b1);
      nop("c5", R, R, 1'b0, 1'b1);
      alu("c6", 5'd1, 5'd2, 5'd0, R, R, 1'b0, 1'b1);
      alu("c7", 5'd0, 5'd7, 5'd6, R, R, 1'b0, 1'b0);
      nop("c8_x0", R, R, 1'b0, 1'b0);
      nop("c9", R, R, 1'b0, 1'b1);

      // MEM/WB forwarding, MEM priority, distance 3.
      alu("d1", 5'd1, 5'd2, 5'd5, R, R, 1'b0, 1'b1);
      nop("d2", R, R, 1'b0, 1'b0);
      alu("d3", 5'd1, 5'd5, 5'd8, R, R, 1'b0, 1'b1);
      nop("d4_memwb", R, W, 1'b0, 1'b0);
      alu("d5", 5'd1, 5'd2, 5'd5, R, R, 1'b0, 1'b1);
      alu("d6", 5'd1, 5'd2, 5'd5, R, R, 1'b0, 1'b0);
      alu("d7", 5'd5, 5'd5, 5'd9, R, R, 1'b0, 1'b0);
      nop("d8_prio", M, M, 1'b0, 1'b0);
      nop("d9", R, R, 1'b0, 1'b1);
      alu("d10", 5'd1, 5'd2, 5'd12, R, R, 1'b0, 1'b1);
      nop("d11", R, R, 1'b0, 1'b0);
      nop("d12", R, R, 1'b0, 1'b1);
      alu("d13", 5'd12, 5'd12, 5'd13, R, R, 1'b0, 1'b1);
      nop("d14_dist3", R, R, 1'b0, 1'b0);

      // Load-use: one stall, a bubble, then the load result from MEM/WB.
      cyc("l1", 1'b0, 1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, R, R, 1'b0, 1'b1);
      alu("l2_stall", 5'd3, 5'd2, 5'd4, R, R, 1'b1, 1'b0);
      alu("l3_bubble", 5'd3, 5'd2, 5'd4, R, R, 1'b0, 1'b1);
      nop("l4_fwd", W, R, 1'b0, 1'b0);
      nop("l5", R, R, 1'b0, 1'b1);
      cyc("l6", 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, R, R, 1'b0, 1'b1);
      alu("l7_x0_nostall", 5'd0, 5'd2, 5'd4, R, R, 1'b0, 1'b0);
      nop("l8", R, R, 1'b0, 1'b0);
      nop("l9", R, R, 1'b0, 1'b1);

      // MUL/DIV: producer of x14 shows the MEM bubbles behind the frozen MUL.
      alu("m0", 5'd2, 5'd2, 5'd14, R, R, 1'b0, 1'b1);
      cyc("m1", 1'b0, 1'b1, 5'd1, 5'd14, 5'd10, 1'b1, 1'b0, 1'b1, R, R, 1'b0, 1'b0);
`ifdef HAZARD_MULDIV_EN
      alu("m2_busy", 5'd10, 5'd1, 5'd11, R, M, 1'b1, 1'b0);
      alu("m3_busy", 5'd10, 5'd1, 5'd11, R, W, 1'b1, 1'b0);
      alu("m4_busy", 5'd10, 5'd1, 5'd11, R, R, 1'b1, 1'b0);
      alu("m5_last", 5'd10, 5'd1, 5'd11, R, R, 1'b0, 1'b0);
      nop("m6_fwd", M, R, 1'b0, 1'b0);
      nop("m7", R, R, 1'b0, 1'b1);
`else
      alu("m2_nostall", 5'd10, 5'd1, 5'd11, R, M, 1'b0, 1'b0);
      nop("m3_fwd", M, R, 1'b0, 1'b0);
      nop("m4", R, R, 1'b0, 1'b1);
`endif

      // Reset asserted in the second busy cycle.
      cyc("r1", 1'b0, 1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b1, R, R, 1'b0, 1'b1);
`ifdef HAZARD_MULDIV_EN
      alu("r2_busy", 5'd10, 5'd1, 5'd11, R, R, 1'b1, 1'b0);
      cyc("r3_rst", 1'b1, 1'b1, 5'd10, 5'd1, 5'd11, 1'b1, 1'b0, 1'b0, R, R, 1'b1, 1'b0);
`else
      alu("r2", 5'd10, 5'd1, 5'd11, R, R, 1'b0, 1'b0);
      cyc("r3_rst", 1'b1, 1'b1, 5'd10, 5'd1, 5'd11, 1'b1, 1'b0, 1'b0, M, R, 1'b0, 1'b0);
`endif
      alu("r4_after", 5'd10, 5'd1, 5'd11, R, R, 1'b0, 1'b1);
      nop("r5", R, R, 1'b0, 1'b0);
      nop("r6", R, R, 1'b0, 1'b1);

      @(negedge CLK);
      #1;
      check("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
